// File: rtl/hdb3_decoder.sv
// ----------------------------------------------------------------------------
// hdb3_decoder
//   Receive-side HDB3 decoder. Accepts one bipolar line symbol per qualified
//   cycle, detects V pulses (same polarity as the previous pulse), strips the
//   000V / B00V substitutions and emits the recovered NRZ stream four accepted
//   symbols later. code_err strobes on illegal symbols, non-alternating V
//   pulses and runs of four or more zeros.
//   Optional feature macro: HDB3_ERR_CNT_EN adds a saturating err_cnt output
//   of width ERR_CNT_W.
// ----------------------------------------------------------------------------
module hdb3_decoder
`ifdef HDB3_ERR_CNT_EN
#(
    parameter int ERR_CNT_W = 8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] datain,
    input  logic       datain_valid,
    output logic       dataout,
    output logic       dataout_valid,
    output logic       code_err
`ifdef HDB3_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // Mark shift register: bit 0 newest symbol, bit 3 oldest.
    logic [3:0] sr_q, sr_d;
    logic [2:0] fill_q, fill_d;
    logic [2:0] zrun_q, zrun_d;
    logic       last_pos_q, last_pos_d;
    logic       last_v_pos_q, last_v_pos_d;
    logic       v_seen_q, v_seen_d;
    logic       dataout_q, dataout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       code_err_q, code_err_d;

    logic       pulse_s;
    logic       pol_s;
    logic       viol_s;
    logic       illegal_s;
    logic       zero_s;

    // Symbol classification for the current input.
    always_comb begin
        pulse_s   = (datain == 2'b01) || (datain == 2'b10);
        pol_s     = (datain == 2'b01);
        illegal_s = (datain == 2'b11);
        zero_s    = (datain == 2'b00);
        viol_s    = pulse_s && (pol_s == last_pos_q);
    end

    // Next-state logic: everything holds unless a symbol is accepted.
    always_comb begin
        sr_d         = sr_q;
        fill_d       = fill_q;
        zrun_d       = zrun_q;
        last_pos_d   = last_pos_q;
        last_v_pos_d = last_v_pos_q;
        v_seen_d     = v_seen_q;
        dataout_d    = dataout_q;
        dout_valid_d = 1'b0;
        code_err_d   = 1'b0;

        if (datain_valid) begin
            dataout_d    = sr_q[3];
            dout_valid_d = (fill_q == 3'd4);

            // A V wipes the whole window: the V itself and any B three symbols back.
            if (viol_s) begin
                sr_d = 4'b0000;
            end else begin
                sr_d = {sr_q[2:0], pulse_s};
            end

            if (fill_q == 3'd4) begin
                fill_d = 3'd4;
            end else begin
                fill_d = fill_q + 3'd1;
            end

            // Illegal symbols leave the zero run untouched.
            if (pulse_s) begin
                zrun_d     = 3'd0;
                last_pos_d = pol_s;
            end else if (zero_s) begin
                if (zrun_q == 3'd4) begin
                    zrun_d = 3'd4;
                end else begin
                    zrun_d = zrun_q + 3'd1;
                end
            end else begin
                zrun_d = zrun_q;
            end

            if (viol_s) begin
                last_v_pos_d = pol_s;
                v_seen_d     = 1'b1;
            end else begin
                last_v_pos_d = last_v_pos_q;
            end

            // zrun saturates at 4, so >=3 keeps flagging every further zero.
            code_err_d = illegal_s
                       || (viol_s && (pol_s == last_v_pos_q) && v_seen_q)
                       || (zero_s && (zrun_q >= 3'd3));
        end else begin
            dout_valid_d = 1'b0;
            code_err_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q         <= 4'b0000;
            fill_q       <= 3'd0;
            zrun_q       <= 3'd0;
            last_pos_q   <= 1'b0;
            last_v_pos_q <= 1'b0;
            v_seen_q     <= 1'b0;
            dataout_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            fill_q       <= fill_d;
            zrun_q       <= zrun_d;
            last_pos_q   <= last_pos_d;
            last_v_pos_q <= last_v_pos_d;
            v_seen_q     <= v_seen_d;
            dataout_q    <= dataout_d;
            dout_valid_q <= dout_valid_d;
            code_err_q   <= code_err_d;
        end
    end

    assign dataout       = dataout_q;
    assign dataout_valid = dout_valid_q;
    assign code_err      = code_err_q;

`ifdef HDB3_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of code_err strobes.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (code_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// ----------------------------------------------------------------------------
// tb_hdb3_decoder
//   Directed bench for hdb3_decoder. Each driven symbol pushes its expected
//   decoded bit into a scoreboard queue (retroactively zeroing the B window
//   when the step is marked as a V); bits are popped when dataout_valid fires.
// ----------------------------------------------------------------------------
module tb_hdb3_decoder;

    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] I = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] datain;
    logic       datain_valid;
    logic       dataout;
    logic       dataout_valid;
    logic       code_err;
`ifdef HDB3_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;
    int   exp_errs = 0;
    logic last_out = 1'b0;
    logic exp_q[$];

    always #5 clk = ~clk;

    hdb3_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .datain        (datain),
        .datain_valid  (datain_valid),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .code_err      (code_err)
`ifdef HDB3_ERR_CNT_EN
        ,
        .err_cnt       (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one accepted symbol and check the resulting outputs.
    task automatic sym(input logic [1:0] s, input logic bit_v, input logic kill, input logic exp_err);
        logic vexp;
        logic e;
        if (kill) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_q.size() > i) exp_q[exp_q.size()-1-i] = 1'b0;
            end
        end
        vexp = (accepts >= 4);
        exp_q.push_back(kill ? 1'b0 : bit_v);
        datain       = s;
        datain_valid = 1'b1;
        @(posedge clk);
        #1;
        datain_valid = 1'b0;
        accepts++;
        if (exp_err) exp_errs++;
        chk("code_err", {31'd0, code_err}, {31'd0, exp_err});
        chk("dataout_valid", {31'd0, dataout_valid}, {31'd0, vexp});
        if (dataout_valid) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dataout", {31'd0, dataout}, {31'd0, e});
                last_out = e;
            end
        end
    endtask

    // Stall cycles: outputs must hold, strobes low.
    task automatic idle(input int n);
        datain_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'd0, dataout_valid}, 32'd0);
            chk("stall_err", {31'd0, code_err}, 32'd0);
            chk("stall_dataout", {31'd0, dataout}, {31'd0, last_out});
        end
    endtask

    task automatic do_reset();
        datain_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_dataout", {31'd0, dataout}, 32'd0);
        chk("rst_valid", {31'd0, dataout_valid}, 32'd0);
        chk("rst_code_err", {31'd0, code_err}, 32'd0);
`ifdef HDB3_ERR_CNT_EN
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        exp_q.delete();
        accepts  = 0;
        last_out = 1'b0;
        exp_errs = 0;
    endtask

    initial begin
        reset        = 1'b1;
        datain       = 2'b00;
        datain_valid = 1'b0;
        do_reset();
        do_reset();

        // Alternating marks, no substitutions.
        sym(P,1,0,0); sym(N,1,0,0); sym(P,1,0,0); sym(N,1,0,0);
        sym(P,1,0,0); sym(N,1,0,0); sym(P,1,0,0); sym(N,1,0,0);

        // 000V after a + pulse (first V since reset).
        sym(P,1,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(P,0,1,0);

        // B00V with alternating V polarity.
        sym(N,1,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(N,0,1,0);

        // Two + V pulses with no pulse between: second one is non-alternating.
        sym(P,1,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(P,0,1,0);
        sym(Z,0,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(P,0,1,1);

        // Illegal symbol, zero-run violations, illegal inside a zero run.
        sym(N,1,0,0); sym(I,0,0,1); sym(P,1,0,0);
        sym(Z,0,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(Z,0,0,1); sym(Z,0,0,1);
        sym(N,1,0,0); sym(Z,0,0,0); sym(Z,0,0,0); sym(I,0,0,1); sym(Z,0,0,0); sym(Z,0,0,1);
        sym(P,1,0,0);
        sym(N,1,0,0); sym(P,1,0,0); sym(N,1,0,0); sym(P,1,0,0);
`ifdef HDB3_ERR_CNT_EN
        chk("err_cnt_run", {24'd0, err_cnt}, exp_errs);
`endif

        // Stall, then reset with the shift register full.
        idle(10);
        do_reset();

        // First V after reset matches reset last_v_pos but must not flag.
        sym(N,0,1,0); sym(P,1,0,0); sym(N,1,0,0); sym(P,1,0,0);
        sym(N,1,0,0);
        // A following same-polarity V now flags.
        sym(Z,0,0,0); sym(Z,0,0,0); sym(N,0,1,1);
        sym(P,1,0,0); sym(N,1,0,0); sym(P,1,0,0); sym(N,1,0,0);
`ifdef HDB3_ERR_CNT_EN
        chk("err_cnt_end", {24'd0, err_cnt}, exp_errs);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
